// File: rtl/sysbus_pkg.sv
// Shared system-bus definitions: command and device codes, tag field layout,
// and the memory responder state encoding.
package sysbus_pkg;

    localparam logic       SYSBUS_READ   = 1'b1;
    localparam logic       SYSBUS_WRITE  = 1'b0;
    localparam logic [3:0] SYSBUS_MEMORY = 4'h1;

    localparam int unsigned TAG_CMD_BIT = 12;
    localparam int unsigned TAG_DEV_LSB = 8;
    localparam int unsigned TAG_DEV_W   = 4;
    localparam int unsigned TAG_ID_LSB  = 0;
    localparam int unsigned TAG_ID_W    = 8;

    localparam int unsigned LINE_BEATS  = 8;
    localparam int unsigned BEAT_W      = 3;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_ACK        = 3'd1,
        ST_READ_WAIT  = 3'd2,
        ST_READ_BEAT  = 3'd3,
        ST_WRITE_DATA = 3'd4
    } resp_state_t;

endpackage

// File: rtl/sysbus_mem_array.sv
// Single-port synchronous line store with a registered read port; the read
// register clears on reset or on request so idle bus data reads as zero.
module sysbus_mem_array #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned ADDR_W = 9
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic              re,
    input  logic              clr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // Storage is deliberately not reset so contents survive a bus reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/sysbus_mem_responder.sv
// Memory-side system bus responder: serves line reads and absorbs line
// write-backs for the data cache, 8 beats per 64-byte line.
module sysbus_mem_responder
    import sysbus_pkg::*;
#(
    parameter int unsigned BUS_DATA_WIDTH = 64,
    parameter int unsigned BUS_TAG_WIDTH  = 13,
    parameter int unsigned MEM_LINES      = 64,
    parameter int unsigned READ_LATENCY   = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      bus_reqcyc,
    input  logic [BUS_DATA_WIDTH-1:0] bus_req,
    input  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    output logic                      bus_reqack,
    output logic                      bus_respcyc,
    output logic [BUS_DATA_WIDTH-1:0] bus_resp,
    output logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
    input  logic                      bus_respack
);

    localparam int unsigned IDX_W  = $clog2(MEM_LINES);
    localparam int unsigned ADDR_W = IDX_W + BEAT_W;
    localparam int unsigned LAT_W  = (READ_LATENCY > 0) ? $clog2(READ_LATENCY + 1) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_BEATS - 1);

    resp_state_t        state, state_n;
    logic [LAT_W-1:0]   lat_cnt, lat_cnt_n;
    logic [BEAT_W-1:0]  beat, beat_n;
    logic [IDX_W-1:0]   line_idx, line_idx_n;
    logic               cmd, cmd_n;
    logic [BUS_TAG_WIDTH-1:0] tag_q, tag_n;
    logic               reqack_n, respcyc_n;

    logic               mem_we, mem_re, mem_clr;
    logic [ADDR_W-1:0]  mem_addr;

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            lat_cnt     <= '0;
            beat        <= '0;
            line_idx    <= '0;
            cmd         <= SYSBUS_WRITE;
            tag_q       <= '0;
            bus_reqack  <= 1'b0;
            bus_respcyc <= 1'b0;
        end else begin
            state       <= state_n;
            lat_cnt     <= lat_cnt_n;
            beat        <= beat_n;
            line_idx    <= line_idx_n;
            cmd         <= cmd_n;
            tag_q       <= tag_n;
            bus_reqack  <= reqack_n;
            bus_respcyc <= respcyc_n;
        end
    end

    assign bus_resptag = tag_q;

    // Next state, counters and RAM control; read addresses are issued on the
    // edge entering or advancing a beat so the data register lines up with respcyc.
    always_comb begin
        state_n    = state;
        lat_cnt_n  = lat_cnt;
        beat_n     = beat;
        line_idx_n = line_idx;
        cmd_n      = cmd;
        tag_n      = tag_q;
        mem_we     = 1'b0;
        mem_re     = 1'b0;
        mem_clr    = 1'b0;
        mem_addr   = {line_idx, beat};

        case (state)
            ST_IDLE: begin
                if (bus_reqcyc && (bus_reqtag[TAG_DEV_LSB +: TAG_DEV_W] == SYSBUS_MEMORY)) begin
                    state_n    = ST_ACK;
                    line_idx_n = bus_req[6 +: IDX_W];
                    cmd_n      = bus_reqtag[TAG_CMD_BIT];
                    tag_n      = bus_reqtag;
                end
            end
            ST_ACK: begin
                beat_n = '0;
                if (cmd == SYSBUS_READ) begin
                    if (READ_LATENCY == 0) begin
                        state_n  = ST_READ_BEAT;
                        mem_re   = 1'b1;
                        mem_addr = {line_idx, BEAT_W'(0)};
                    end else begin
                        state_n   = ST_READ_WAIT;
                        lat_cnt_n = LAT_W'(READ_LATENCY);
                    end
                end else begin
                    state_n = ST_WRITE_DATA;
                end
            end
            ST_READ_WAIT: begin
                lat_cnt_n = LAT_W'(lat_cnt - LAT_W'(1));
                if (lat_cnt <= LAT_W'(1)) begin
                    state_n   = ST_READ_BEAT;
                    lat_cnt_n = '0;
                    mem_re    = 1'b1;
                    mem_addr  = {line_idx, BEAT_W'(0)};
                end
            end
            ST_READ_BEAT: begin
                if (bus_respack) begin
                    if (beat == LAST_BEAT) begin
                        state_n = ST_IDLE;
                        beat_n  = '0;
                        mem_clr = 1'b1;
                    end else begin
                        beat_n   = BEAT_W'(beat + BEAT_W'(1));
                        mem_re   = 1'b1;
                        mem_addr = {line_idx, BEAT_W'(beat + BEAT_W'(1))};
                    end
                end
            end
            ST_WRITE_DATA: begin
                if (bus_reqcyc) begin
                    mem_we = 1'b1;
                    if (beat == LAST_BEAT) begin
                        state_n = ST_IDLE;
                        beat_n  = '0;
                    end else begin
                        beat_n = BEAT_W'(beat + BEAT_W'(1));
                    end
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase

        reqack_n  = (state_n == ST_ACK);
        respcyc_n = (state_n == ST_READ_BEAT);
    end

    sysbus_mem_array #(
        .DATA_W (BUS_DATA_WIDTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .reset (reset),
        .we    (mem_we),
        .re    (mem_re),
        .clr   (mem_clr),
        .addr  (mem_addr),
        .wdata (bus_req),
        .rdata (bus_resp)
    );

endmodule
